// File: rtl/lockstep_mem_responder.sv
// lockstep_mem_responder: data-memory responder for a dual-core lockstep pair.
// Waits for both cores to present the same request, compares the fields, then
// performs one byte-enabled access to an internal word array and returns one
// identical response to both cores. Divergence (field mismatch or a peer that
// never arrives) is flagged on the sticky mismatch outputs.
// Optional build macro MISMATCH_COUNT_EN adds a saturating divergence counter
// on mismatch_cnt_o.
// MEM_WORDS must be a power of 2 and at least 2; SKEW_MAX is 1..15.
module lockstep_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int SKEW_MAX  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_req_i,
  output logic        a_gnt_o,
  output logic        a_rvalid_o,
  input  logic        a_we_i,
  input  logic [3:0]  a_be_i,
  input  logic [31:0] a_addr_i,
  input  logic [31:0] a_wdata_i,
  output logic [31:0] a_rdata_o,
  output logic        a_err_o,
  input  logic        b_req_i,
  output logic        b_gnt_o,
  output logic        b_rvalid_o,
  input  logic        b_we_i,
  input  logic [3:0]  b_be_i,
  input  logic [31:0] b_addr_i,
  input  logic [31:0] b_wdata_i,
  output logic [31:0] b_rdata_o,
  output logic        b_err_o,
  output logic        mismatch_o,
  output logic [31:0] mismatch_addr_o
`ifdef MISMATCH_COUNT_EN
  ,
  output logic [15:0] mismatch_cnt_o
`endif
);

  localparam int IDXW = $clog2(MEM_WORDS);
  localparam logic [3:0] SKEW_LIM = 4'(SKEW_MAX);

  // WAIT_A: core B is waiting for A; WAIT_B: core A is waiting for B
  typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B, RESP} state_t;

  state_t state_q, state_d;
  logic [3:0] skew_q, skew_d;

  logic exec;        // both cores granted, access executes at this edge
  logic tmo_a;       // core A waited too long for B
  logic tmo_b;       // core B waited too long for A
  logic fields_match;
  logic out_of_range;
  logic [IDXW-1:0] idx;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] rdata_q;

  // The full address (including ignored bits [1:0]) must agree between cores.
  assign fields_match = (a_we_i == b_we_i) && (a_be_i == b_be_i) &&
                        (a_addr_i == b_addr_i) &&
                        (!a_we_i || (a_wdata_i == b_wdata_i));
  assign out_of_range = |(a_addr_i >> (IDXW + 2));
  assign idx          = a_addr_i[IDXW+1:2];

  assign a_rdata_o = rdata_q;
  assign b_rdata_o = rdata_q;

  // State register and skew counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      skew_q  <= '0;
    end else begin
      state_q <= state_d;
      skew_q  <= skew_d;
    end
  end

  // Next state, grants and execute/timeout strobes; nothing is granted in reset
  always_comb begin
    state_d = state_q;
    skew_d  = skew_q;
    a_gnt_o = 1'b0;
    b_gnt_o = 1'b0;
    exec    = 1'b0;
    tmo_a   = 1'b0;
    tmo_b   = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (a_req_i && b_req_i) begin
            a_gnt_o = 1'b1;
            b_gnt_o = 1'b1;
            exec    = 1'b1;
            state_d = RESP;
          end else if (a_req_i) begin
            skew_d  = 4'd1;
            state_d = WAIT_B;
          end else if (b_req_i) begin
            skew_d  = 4'd1;
            state_d = WAIT_A;
          end
        end
        WAIT_B: begin
          if (b_req_i) begin
            a_gnt_o = 1'b1;
            b_gnt_o = 1'b1;
            exec    = 1'b1;
            skew_d  = '0;
            state_d = RESP;
          end else if (skew_q == SKEW_LIM) begin
            a_gnt_o = 1'b1;
            tmo_a   = 1'b1;
            skew_d  = '0;
            state_d = RESP;
          end else begin
            skew_d  = skew_q + 4'd1;
          end
        end
        WAIT_A: begin
          if (a_req_i) begin
            a_gnt_o = 1'b1;
            b_gnt_o = 1'b1;
            exec    = 1'b1;
            skew_d  = '0;
            state_d = RESP;
          end else if (skew_q == SKEW_LIM) begin
            b_gnt_o = 1'b1;
            tmo_b   = 1'b1;
            skew_d  = '0;
            state_d = RESP;
          end else begin
            skew_d  = skew_q + 4'd1;
          end
        end
        RESP: begin
          skew_d  = '0;
          state_d = IDLE;
        end
        default: begin
          skew_d  = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Byte-enabled write of a matched, in-range request; array is never reset
  always_ff @(posedge clk_i) begin
    if (exec && fields_match && !out_of_range && a_we_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (a_be_i[i]) mem[idx][8*i +: 8] <= a_wdata_i[8*i +: 8];
      end
    end
  end

  // Response registers and sticky divergence capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_rvalid_o      <= 1'b0;
      b_rvalid_o      <= 1'b0;
      a_err_o         <= 1'b0;
      b_err_o         <= 1'b0;
      rdata_q         <= '0;
      mismatch_o      <= 1'b0;
      mismatch_addr_o <= '0;
    end else begin
      a_rvalid_o <= 1'b0;
      b_rvalid_o <= 1'b0;
      a_err_o    <= 1'b0;
      b_err_o    <= 1'b0;
      if (exec) begin
        a_rvalid_o <= 1'b1;
        b_rvalid_o <= 1'b1;
        if (!fields_match) begin
          a_err_o    <= 1'b1;
          b_err_o    <= 1'b1;
          rdata_q    <= '0;
          mismatch_o <= 1'b1;
          if (!mismatch_o) mismatch_addr_o <= a_addr_i;
        end else if (out_of_range) begin
          a_err_o <= 1'b1;
          b_err_o <= 1'b1;
          rdata_q <= '0;
        end else begin
          // non-blocking read returns the pre-write word on a write
          rdata_q <= mem[idx];
        end
      end else if (tmo_a) begin
        a_rvalid_o <= 1'b1;
        a_err_o    <= 1'b1;
        rdata_q    <= '0;
        mismatch_o <= 1'b1;
        if (!mismatch_o) mismatch_addr_o <= a_addr_i;
      end else if (tmo_b) begin
        b_rvalid_o <= 1'b1;
        b_err_o    <= 1'b1;
        rdata_q    <= '0;
        mismatch_o <= 1'b1;
        if (!mismatch_o) mismatch_addr_o <= b_addr_i;
      end
    end
  end

`ifdef MISMATCH_COUNT_EN
  // Saturating count of field mismatches and timeouts
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mismatch_cnt_o <= '0;
    end else if (((exec && !fields_match) || tmo_a || tmo_b) &&
                 (mismatch_cnt_o != '1)) begin
      mismatch_cnt_o <= mismatch_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lockstep_mem_responder.sv
// Self-checking bench for lockstep_mem_responder: directed steps plus random
// transactions compared against a word-array reference model.
module tb_lockstep_mem_responder;

  localparam int MEM_WORDS = 1024;
  localparam int SKEW_MAX  = 4;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  logic a_req, a_gnt, a_rvalid, a_we, a_err;
  logic [3:0] a_be;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic b_req, b_gnt, b_rvalid, b_we, b_err;
  logic [3:0] b_be;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic mismatch;
  logic [31:0] mm_addr;
`ifdef MISMATCH_COUNT_EN
  logic [15:0] mm_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] m_mem [MEM_WORDS];
  logic        m_mm;
  logic [31:0] m_addr;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  lockstep_mem_responder #(.MEM_WORDS(MEM_WORDS), .SKEW_MAX(SKEW_MAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_we_i(a_we),
    .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_rdata_o(a_rdata),
    .a_err_o(a_err),
    .b_req_i(b_req), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_we_i(b_we),
    .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_rdata_o(b_rdata),
    .b_err_o(b_err),
    .mismatch_o(mismatch), .mismatch_addr_o(mm_addr)
`ifdef MISMATCH_COUNT_EN
    , .mismatch_cnt_o(mm_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic note_div(input logic [31:0] addr);
    if (!m_mm) begin
      m_mm   = 1'b1;
      m_addr = addr;
    end
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  // Reference behaviour of one jointly granted request
  task automatic model_exec(input req_t ra, input req_t rb, output logic [31:0] rd, output logic er);
    bit match;
    int w;
    match = (ra.we == rb.we) && (ra.be == rb.be) && (ra.addr == rb.addr) &&
            (!ra.we || ra.wdata == rb.wdata);
    if (!match) begin
      er = 1'b1; rd = '0; note_div(ra.addr);
    end else if (ra.addr >= 32'(MEM_WORDS * 4)) begin
      er = 1'b1; rd = '0;
    end else begin
      w  = int'(ra.addr / 4);
      rd = m_mem[w];
      er = 1'b0;
      if (ra.we)
        for (int i = 0; i < 4; i++)
          if (ra.be[i]) m_mem[w][8*i +: 8] = ra.wdata[8*i +: 8];
    end
  endtask

  task automatic check_sticky();
    check("mismatch", mismatch, m_mm);
    check("mismatch_addr", mm_addr, m_addr);
`ifdef MISMATCH_COUNT_EN
    check("mismatch_cnt", mm_cnt, m_cnt);
`endif
  endtask

  // lag > 0: B requests lag cycles after A; lag < 0: A after B.
  // solo 1: only A requests, solo 2: only B requests (timeout expected).
  task automatic txn(input req_t ra, input req_t rb, input int lag, input int solo,
                     output logic [31:0] rd_obs, output logic err_obs);
    int a_start, b_start, g;
    bit ga, gb, tmo;
    logic [31:0] exp_rd;
    logic exp_err;
    a_start = (solo == 0 && lag < 0) ? -lag : 0;
    b_start = (solo == 0 && lag > 0) ? lag : 0;
    tmo = (solo != 0);
    g   = tmo ? SKEW_MAX : (lag < 0 ? -lag : lag);
    ga  = (solo != 2);
    gb  = (solo != 1);
    for (int c = 0; c <= g; c++) begin
      @(negedge clk);
      a_req = ga && (c >= a_start);
      b_req = gb && (c >= b_start);
      a_we = ra.we; a_be = ra.be; a_addr = ra.addr; a_wdata = ra.wdata;
      b_we = rb.we; b_be = rb.be; b_addr = rb.addr; b_wdata = rb.wdata;
      #1;
      if (c == 0) begin
        check("a_rvalid_idle", a_rvalid, 1'b0);
        check("b_rvalid_idle", b_rvalid, 1'b0);
      end
      check("a_gnt", a_gnt, (c == g) && ga);
      check("b_gnt", b_gnt, (c == g) && gb);
    end
    if (tmo) begin
      exp_err = 1'b1;
      exp_rd  = 'x;
      note_div(solo == 1 ? ra.addr : rb.addr);
    end else begin
      model_exec(ra, rb, exp_rd, exp_err);
    end
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
    #1;
    check("a_rvalid", a_rvalid, ga);
    check("b_rvalid", b_rvalid, gb);
    check("a_gnt_resp", a_gnt, 1'b0);
    check("b_gnt_resp", b_gnt, 1'b0);
    if (ga) check("a_err", a_err, exp_err);
    if (gb) check("b_err", b_err, exp_err);
    if (!tmo && !$isunknown(exp_rd)) begin
      check("a_rdata", a_rdata, exp_rd);
      check("b_rdata", b_rdata, exp_rd);
    end
    check_sticky();
    rd_obs  = a_rdata;
    err_obs = ga ? a_err : b_err;
  endtask

  function automatic req_t mk(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.we    = 1'($urandom);
    r.be    = 4'($urandom);
    r.addr  = 32'($urandom_range(0, 255));
    r.wdata = $urandom;
    if ($urandom_range(0, 9) == 0)
      r.addr = r.addr | ($urandom_range(0, 1) != 0 ? 32'h0000_1000 : 32'h8000_0000);
    return r;
  endfunction

  function automatic req_t perturb(input req_t r);
    req_t p;
    p = r;
    case ($urandom_range(0, 3))
      0: p.we    = ~r.we;
      1: p.be    = r.be ^ 4'h1;
      2: p.addr  = r.addr ^ 32'h4;
      default: p.wdata = r.wdata ^ 32'h1;
    endcase
    return p;
  endfunction

  initial begin
    req_t ra, rb;
    logic [31:0] rd;
    logic er;
    int lag, sel;

    rst = 1'b1;
    a_req = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_be = '0; b_addr = '0; b_wdata = '0;
    m_mm = 1'b0; m_addr = '0; m_cnt = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_a_rvalid", a_rvalid, 1'b0);
    check("rst_b_rvalid", b_rvalid, 1'b0);
    check("rst_a_gnt", a_gnt, 1'b0);
    check("rst_b_gnt", b_gnt, 1'b0);
    check("rst_a_err", a_err, 1'b0);
    check("rst_b_err", b_err, 1'b0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    check_sticky();
    rst = 1'b0;

    // initialise the first 64 words so random reads see known data
    for (int i = 0; i < 64; i++) begin
      ra = mk(1'b1, 4'hF, 32'(i * 4), $urandom);
      txn(ra, ra, 0, 0, rd, er);
    end

    // full write then read of 0x10
    ra = mk(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    txn(ra, ra, 0, 0, rd, er);
    ra = mk(1'b0, 4'hF, 32'h10, 32'h0);
    txn(ra, ra, 0, 0, rd, er);
    check("tp_read_10", rd, 32'hDEADBEEF);
    check("tp_read_10_err", er, 1'b0);

    // byte-lane 1 write then read
    ra = mk(1'b1, 4'h2, 32'h10, 32'h0000AA00);
    txn(ra, ra, 0, 0, rd, er);
    check("tp_bewrite_prev", rd, 32'hDEADBEEF);
    ra = mk(1'b0, 4'hF, 32'h10, 32'h0);
    txn(ra, ra, 0, 0, rd, er);
    check("tp_bewrite_read", rd, 32'hDEADAAEF);

    // B two cycles late, then A late by SKEW_MAX (boundary: still joint)
    ra = mk(1'b0, 4'hF, 32'h20, 32'h0);
    txn(ra, ra, 2, 0, rd, er);
    txn(ra, ra, -SKEW_MAX, 0, rd, er);
    check("tp_skew_mismatch", mismatch, 1'b0);

    // differing wdata on a read is not a divergence
    ra = mk(1'b0, 4'hF, 32'h20, 32'h1111_1111);
    rb = mk(1'b0, 4'hF, 32'h20, 32'h2222_2222);
    txn(ra, rb, 0, 0, rd, er);
    check("tp_rd_wdata_ok", er, 1'b0);

    // matched out-of-range read
    ra = mk(1'b0, 4'hF, 32'h0001_0000, 32'h0);
    txn(ra, ra, 0, 0, rd, er);
    check("tp_oor_err", er, 1'b1);
    check("tp_oor_rdata", rd, 32'h0);
    check("tp_oor_mismatch", mismatch, 1'b0);

    // random matched traffic with skew
    for (int n = 0; n < 120; n++) begin
      ra  = rand_req();
      lag = int'($urandom_range(0, 2 * SKEW_MAX)) - SKEW_MAX;
      txn(ra, ra, lag, 0, rd, er);
    end

    // field mismatch on a write to 0x30
    ra = mk(1'b1, 4'hF, 32'h30, 32'h1);
    rb = mk(1'b1, 4'hF, 32'h30, 32'h2);
    txn(ra, rb, 0, 0, rd, er);
    check("tp_mm_err", er, 1'b1);
    check("tp_mm_flag", mismatch, 1'b1);
    check("tp_mm_addr", mm_addr, 32'h30);
    ra = mk(1'b0, 4'hF, 32'h30, 32'h0);
    txn(ra, ra, 0, 0, rd, er);
    check("tp_mm_unchanged", rd, m_mem[12]);

    // lone A then lone B: timeouts, first address stays captured
    ra = mk(1'b0, 4'hF, 32'h44, 32'h0);
    txn(ra, ra, 0, 1, rd, er);
    check("tp_tmo_a_err", er, 1'b1);
    rb = mk(1'b1, 4'h3, 32'h48, 32'h5);
    txn(rb, rb, 0, 2, rd, er);
    check("tp_tmo_b_err", er, 1'b1);
    check("tp_tmo_addr", mm_addr, 32'h30);

    // random mix of matched, divergent and lone requests
    for (int n = 0; n < 120; n++) begin
      ra  = rand_req();
      sel = int'($urandom_range(0, 9));
      lag = int'($urandom_range(0, 2 * SKEW_MAX)) - SKEW_MAX;
      if (sel == 0)      txn(ra, ra, 0, 1, rd, er);
      else if (sel == 1) txn(ra, ra, 0, 2, rd, er);
      else if (sel < 5)  txn(ra, perturb(ra), lag, 0, rd, er);
      else               txn(ra, ra, lag, 0, rd, er);
    end

    // reset during RESP drops the response but keeps the written word
    ra = mk(1'b1, 4'hF, 32'h50, 32'hCAFEF00D);
    @(negedge clk);
    a_req = 1'b1; b_req = 1'b1;
    a_we = ra.we; a_be = ra.be; a_addr = ra.addr; a_wdata = ra.wdata;
    b_we = ra.we; b_be = ra.be; b_addr = ra.addr; b_wdata = ra.wdata;
    #1;
    check("rr_a_gnt", a_gnt, 1'b1);
    check("rr_b_gnt", b_gnt, 1'b1);
    model_exec(ra, ra, rd, er);
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0; rst = 1'b1;
    #1;
    check("rr_rvalid_before", a_rvalid, 1'b1);
    @(negedge clk);
    #1;
    check("rr_a_rvalid", a_rvalid, 1'b0);
    check("rr_b_rvalid", b_rvalid, 1'b0);
    check("rr_a_err", a_err, 1'b0);
    check("rr_rdata", a_rdata, 32'h0);
    m_mm = 1'b0; m_addr = '0; m_cnt = '0;
    check_sticky();
    rst = 1'b0;
    ra = mk(1'b0, 4'hF, 32'h50, 32'h0);
    txn(ra, ra, 0, 0, rd, er);
    check("rr_kept_write", rd, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
